// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID register: owns the PC and latches the fetched word one edge after PC is presented.
// Priority per edge is halt > redirect (one bubble) > stall (hold everything) > normal fetch.
module fetch_stage #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter logic [31:0]      NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic [31:0]     if_id_inst,
    output logic            if_id_valid,
    output logic [6:0]      part_of_inst,
    output logic            misaligned,
    output logic            halted,
    output logic [31:0]     fetch_count
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic [31:0]     if_id_inst_q, if_id_inst_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic            misaligned_q, misaligned_d;
    logic            halted_q, halted_d;
    logic [31:0]     fetch_count_q, fetch_count_d;

    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        pc_d             = pc_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_inst_d     = if_id_inst_q;
        if_id_valid_d    = if_id_valid_q;
        misaligned_d     = 1'b0;
        halted_d         = halted_q;
        fetch_count_d    = fetch_count_q;

        if (halt || halted_q) begin
            // Frozen: PC and pc fields keep their last values, only a bubble enters ID.
            halted_d      = 1'b1;
            if_id_inst_d  = NOP_INST;
            if_id_valid_d = 1'b0;
        end else if (redirect) begin
            // Both low bits are forced to zero; bit 1 set means the target was not word aligned.
            pc_d          = redirect_target & ~XLEN'(3);
            misaligned_d  = redirect_target[1];
            if_id_inst_d  = NOP_INST;
            if_id_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d             = pc_plus4;
            if_id_pc_d       = pc_q;
            if_id_pc_plus4_d = pc_plus4;
            if_id_inst_d     = imem_rdata;
            if_id_valid_d    = 1'b1;
            fetch_count_d    = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q             <= RESET_PC;
            if_id_pc_q       <= '0;
            if_id_pc_plus4_q <= '0;
            if_id_inst_q     <= NOP_INST;
            if_id_valid_q    <= 1'b0;
            misaligned_q     <= 1'b0;
            halted_q         <= 1'b0;
            fetch_count_q    <= '0;
        end else begin
            pc_q             <= pc_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_inst_q     <= if_id_inst_d;
            if_id_valid_q    <= if_id_valid_d;
            misaligned_q     <= misaligned_d;
            halted_q         <= halted_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_inst     = if_id_inst_q;
    assign if_id_valid    = if_id_valid_q;
    assign part_of_inst   = if_id_inst_q[6:0];
    assign misaligned     = misaligned_q;
    assign halted         = halted_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect traffic against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, redirect, halt;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_id_pc, if_id_pc_plus4, if_id_inst, fetch_count;
    logic        if_id_valid, misaligned, halted;
    logic [6:0]  part_of_inst;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural view of the stage: what ID should currently see.
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_inst, m_cnt;
    logic        m_valid, m_mis, m_halted;

    fetch_stage dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .halt(halt), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_inst(if_id_inst), .if_id_valid(if_id_valid), .part_of_inst(part_of_inst),
        .misaligned(misaligned), .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00A0_0113;
            32'h8:   return 32'h0020_81B3;
            32'hC:   return 32'h0000_0013;
            default: return {a[24:0] ^ 25'h1A5_5A5A, 7'b0110111};
        endcase
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    task automatic model_reset();
        m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_inst = 32'h13;
        m_valid = 1'b0; m_mis = 1'b0; m_halted = 1'b0; m_cnt = 32'h0;
    endtask

    // One clock edge: apply inputs, advance the model by the stage's rules, settle past the edge.
    task automatic step(input logic st, input logic rd, input logic [31:0] tg, input logic ht);
        stall = st; redirect = rd; redirect_target = tg; halt = ht;
        @(posedge clk);
        m_mis = 1'b0;
        if (ht || m_halted) begin
            m_halted = 1'b1; m_inst = 32'h13; m_valid = 1'b0;
        end else if (rd) begin
            m_pc = {tg[31:2], 2'b00}; m_mis = tg[1]; m_inst = 32'h13; m_valid = 1'b0;
        end else if (!st) begin
            m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_inst = imem_word(m_pc);
            m_valid = 1'b1; m_cnt = m_cnt + 32'd1; m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; stall = 0; redirect = 0; halt = 0; redirect_target = 0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall = 0; redirect = 0; halt = 0; redirect_target = 0;
        model_reset();
        #12;
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", imem_addr); end
        n_checks++; if (if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_ifpc got %h/%h want 0/0", if_id_pc, if_id_pc_plus4); end
        n_checks++; if (if_id_inst !== 32'h13 || part_of_inst !== 7'h13) begin n_fail++; $display("FAIL reset_inst got %h/%h want 13/13", if_id_inst, part_of_inst); end
        n_checks++; if ({if_id_valid, misaligned, halted} !== 3'b000 || fetch_count !== 0) begin n_fail++; $display("FAIL reset_flags got v%b m%b h%b c%0d want 0", if_id_valid, misaligned, halted, fetch_count); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] insts [4];
        logic [6:0]  ops   [4];
        insts = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_0013};
        ops   = '{7'h13, 7'h13, 7'h33, 7'h13};
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            n_checks++;
            if (if_id_pc !== 32'(4 * i) || if_id_pc_plus4 !== 32'(4 * i + 4) || if_id_valid !== 1'b1 ||
                if_id_inst !== insts[i] || part_of_inst !== ops[i])
                begin n_fail++; $display("FAIL seq_%0d got pc %h inst %h op %h v%b want pc %h inst %h op %h v1",
                      i, if_id_pc, if_id_inst, part_of_inst, if_id_valid, 4 * i, insts[i], ops[i]); end
        end
        n_checks++; if (fetch_count !== 32'd4 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL seq_count got %0d addr %h want 4 addr 10", fetch_count, imem_addr); end
    endtask

    task automatic test_stall();
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            n_checks++;
            if (imem_addr !== 32'h8 || if_id_pc !== 32'h4 || if_id_inst !== 32'h00A0_0113 ||
                if_id_valid !== 1'b1 || fetch_count !== 32'd2)
                begin n_fail++; $display("FAIL stall_%0d got addr %h ifpc %h inst %h cnt %0d want 8 4 00a00113 2",
                      i, imem_addr, if_id_pc, if_id_inst, fetch_count); end
        end
        step(0, 0, 0, 0);
        n_checks++; if (if_id_pc !== 32'h8 || if_id_inst !== 32'h0020_81B3 || fetch_count !== 32'd3) begin n_fail++; $display("FAIL stall_resume got ifpc %h inst %h cnt %0d want 8 002081b3 3", if_id_pc, if_id_inst, fetch_count); end
    endtask

    task automatic test_redirect_stall();
        logic [31:0] cnt0;
        cnt0 = fetch_count;
        step(1, 1, 32'h40, 0);
        n_checks++; if (imem_addr !== 32'h40 || if_id_valid !== 1'b0 || if_id_inst !== 32'h13 || misaligned !== 1'b0 || fetch_count !== cnt0)
            begin n_fail++; $display("FAIL redir_bubble got addr %h v%b inst %h m%b cnt %0d want 40 0 13 0 %0d", imem_addr, if_id_valid, if_id_inst, misaligned, fetch_count, cnt0); end
        step(0, 0, 0, 0);
        n_checks++; if (if_id_pc !== 32'h40 || if_id_valid !== 1'b1 || imem_addr !== 32'h44 || if_id_inst !== imem_word(32'h40))
            begin n_fail++; $display("FAIL redir_target got ifpc %h v%b addr %h want 40 1 44", if_id_pc, if_id_valid, imem_addr); end
    endtask

    task automatic test_misaligned();
        step(0, 1, 32'h103, 0);
        n_checks++; if (imem_addr !== 32'h100 || misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_103 got addr %h m%b want 100 1", imem_addr, misaligned); end
        step(0, 0, 0, 0);
        n_checks++; if (misaligned !== 1'b0 || if_id_pc !== 32'h100) begin n_fail++; $display("FAIL mis_pulse got m%b ifpc %h want 0 100", misaligned, if_id_pc); end
        step(0, 1, 32'h101, 0);
        n_checks++; if (imem_addr !== 32'h100 || misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_101 got addr %h m%b want 100 0", imem_addr, misaligned); end
    endtask

    task automatic test_wrap();
        step(0, 1, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 0);
        n_checks++; if (imem_addr !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'h0)
            begin n_fail++; $display("FAIL wrap got addr %h ifpc %h pc4 %h want 0 fffffffc 0", imem_addr, if_id_pc, if_id_pc_plus4); end
    endtask

    task automatic test_random();
        logic st, rd;
        for (int i = 0; i < 300; i++) begin
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 7) == 0);
            step(st, rd, $urandom, 0);
            n_checks++;
            if (imem_addr !== m_pc || if_id_pc !== m_ifpc || if_id_pc_plus4 !== m_ifpc4 || if_id_inst !== m_inst ||
                part_of_inst !== m_inst[6:0] || if_id_valid !== m_valid || misaligned !== m_mis ||
                halted !== m_halted || fetch_count !== m_cnt)
                begin n_fail++; $display("FAIL rand_%0d got addr %h ifpc %h inst %h v%b m%b cnt %0d want %h %h %h v%b m%b cnt %0d",
                      i, imem_addr, if_id_pc, if_id_inst, if_id_valid, misaligned, fetch_count,
                      m_pc, m_ifpc, m_inst, m_valid, m_mis, m_cnt); end
        end
    endtask

    task automatic test_halt();
        logic [31:0] cnt0;
        step(0, 1, 32'h18, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        cnt0 = fetch_count;
        step(0, 1, 32'h80, 1);
        n_checks++; if (halted !== 1'b1 || imem_addr !== 32'h20 || if_id_valid !== 1'b0 || if_id_pc !== 32'h1C || fetch_count !== cnt0 || misaligned !== 1'b0)
            begin n_fail++; $display("FAIL halt_enter got h%b addr %h v%b ifpc %h cnt %0d want 1 20 0 1c %0d", halted, imem_addr, if_id_valid, if_id_pc, fetch_count, cnt0); end
        for (int i = 0; i < 4; i++) begin
            step(i[0], !i[0], 32'h202, 0);
            n_checks++;
            if (halted !== 1'b1 || imem_addr !== 32'h20 || if_id_valid !== 1'b0 || if_id_inst !== 32'h13 ||
                fetch_count !== cnt0 || misaligned !== 1'b0 || halted !== m_halted)
                begin n_fail++; $display("FAIL halt_sticky_%0d got h%b addr %h v%b cnt %0d m%b want 1 20 0 %0d 0", i, halted, imem_addr, if_id_valid, fetch_count, misaligned, cnt0); end
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 0);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (imem_addr !== 32'h0 || halted !== 1'b0 || if_id_valid !== 1'b0 || if_id_inst !== 32'h13 ||
                         fetch_count !== 32'h0 || if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0)
            begin n_fail++; $display("FAIL async_reset got addr %h h%b v%b inst %h cnt %0d ifpc %h want 0 0 0 13 0 0", imem_addr, halted, if_id_valid, if_id_inst, fetch_count, if_id_pc); end
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 0, 0, 0);
        n_checks++; if (if_id_pc !== 32'h0 || if_id_inst !== 32'h0050_0093 || if_id_valid !== 1'b1 || fetch_count !== 32'd1)
            begin n_fail++; $display("FAIL first_fetch got ifpc %h inst %h v%b cnt %0d want 0 00500093 1 1", if_id_pc, if_id_inst, if_id_valid, fetch_count); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_misaligned();
        test_wrap();
        test_random();
        test_halt();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the RV32I pipelined core.
- Owns the PC and drives the instruction-memory address.
- Latches the fetched instruction and feeds opcode bits [6:0] (part_of_inst) directly into the control unit in ID.
- Handles stall from hazard detection, redirect/flush from branch or jump resolution, and sticky halt on ECALL termination.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush or halt.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit: hold PC and IF/ID this cycle.
- redirect  input  1  taken branch, JAL or JALR resolved downstream: load redirect_target and flush IF/ID.
- redirect_target  input  XLEN  next PC on redirect.
- halt  input  1  ECALL termination detected downstream; freezes fetch.
- imem_addr  output  XLEN  instruction-memory address, equal to the current PC (combinational from the PC register).
- imem_rdata  input  32  instruction word at imem_addr; combinational, same-cycle read.
- if_id_pc  output  XLEN  PC of the latched instruction.
- if_id_pc_plus4  output  XLEN  if_id_pc + 4 (for pc_to_reg writeback).
- if_id_inst  output  32  latched instruction.
- if_id_valid  output  1  latched instruction is real, not a bubble.
- part_of_inst  output  7  if_id_inst[6:0], to the control unit.
- misaligned  output  1  one-cycle pulse: redirect_target[1] was set.
- halted  output  1  sticky halt status.
- fetch_count  output  32  number of valid instructions latched into IF/ID.

Behaviour:
- Reset values (asynchronous, while reset_n=0):
  - PC = RESET_PC.
  - if_id_pc = 0, if_id_pc_plus4 = 0, if_id_inst = NOP_INST, if_id_valid = 0.
  - halted = 0, misaligned = 0, fetch_count = 0.
- Releasing reset: the first rising edge with reset_n=1 performs a normal fetch of RESET_PC.
- Per-edge priority, highest first: halted/halt > redirect > stall > normal.
- Halt:
  - If halt=1 or halted=1, set halted=1.
  - PC holds; IF/ID is loaded with NOP_INST, valid=0, pc fields hold.
  - halted stays set until reset; later redirect or stall inputs are ignored.
- Redirect (no halt):
  - PC = {redirect_target[XLEN-1:2], 2'b00}. Bit 0 is cleared per JALR; bit 1 is also cleared.
  - misaligned = redirect_target[1] for that one cycle.
  - IF/ID = NOP_INST, valid=0. The wrong-path instruction is discarded.
  - Redirect overrides a simultaneous stall.
- Stall (no halt, no redirect): PC, all IF/ID fields and fetch_count hold.
- Normal:
  - PC = PC + 4, wrapping modulo 2^XLEN (32'hFFFF_FFFC goes to 0).
  - IF/ID = {PC, PC+4, imem_rdata}, valid=1, fetch_count += 1 (wraps at 2^32).
- misaligned is 0 on every edge that is not a redirect.
- part_of_inst is always if_id_inst[6:0]; during a bubble it is 7'b0010011, so the control unit asserts alu_src and write_enable to x0 only. No separate gating is applied.
- Latency:
  - Instruction at PC appears on IF/ID one edge after PC is presented.
  - A redirect costs one bubble in IF/ID.
  - The redirect target is fetched on the following edge.
- Reset asserted mid-operation takes effect immediately and asynchronously, with no completion of an in-flight fetch.

Test Plan:
- Reset then 4 free-running cycles, imem returns 0x00500093, 0x00A00113, 0x002081B3, 0x00000013 → IF/ID PCs 0, 4, 8, 12 in order; valid=1; part_of_inst 0x13, 0x13, 0x33, 0x13; fetch_count=4.
- stall held for 3 cycles at PC=8 → imem_addr stays 8; IF/ID holds the PC=4 entry; fetch_count unchanged; then resumes with PC=8.
- redirect=1, target=0x40, in the same cycle as stall=1 → next edge: PC=0x40, IF/ID valid=0, inst=0x00000013; following edge latches PC=0x40 with valid=1.
- redirect target=0x103 (JALR odd) → PC=0x100 and misaligned pulses 1 for one cycle. Target=0x101 → PC=0x100, misaligned=0.
- halt pulse at PC=0x20, plus redirect in the same and later cycles → halted=1 and stays 1; PC frozen at 0x20; valid=0; fetch_count frozen.
- PC preloaded via redirect to 0xFFFFFFFC then one normal fetch → PC wraps to 0, if_id_pc_plus4=0. Assert reset_n=0 mid-cycle → outputs reach reset values before the next clock edge.
